// File: rtl/md_hilo_unit.sv
// Iterative radix-2 multiply/divide unit with private HI/LO registers for the MiniSys EXE stage.
// One shift-add (MULT) or restoring-subtract (DIV) step per clock; signs are fixed at the final edge.
module md_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] mt_data,
    input  logic             mf_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             stall_req
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t state, stateNext;

    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] accHi, accLo;
    logic [WIDTH-1:0] opA, opB, aRaw;
    logic             isDiv, negRes, negRem, bZero;

    logic             signedOp, startAccept, mtWrite, lastIter, finish;
    logic [WIDTH-1:0] absA, absB;
    logic [WIDTH:0]   mulSum, divTmp;
    logic [WIDTH-1:0] divDiff;
    logic             divGe;
    logic [WIDTH-1:0] iterHi, iterLo, resHi, resLo;
    logic [2*WIDTH-1:0] prodFix;

    function automatic logic [WIDTH-1:0] condNeg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] condNeg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    assign signedOp    = ~op[0];
    assign absA        = condNeg(a, signedOp & a[WIDTH-1]);
    assign absB        = condNeg(b, signedOp & b[WIDTH-1]);
    assign mtWrite     = mthi_we | mtlo_we;
    assign startAccept = start & ~flush & (state != CALC);
    assign lastIter    = (state == CALC) && (count == LAST);
    assign finish      = lastIter & ~flush & ~mtWrite;

    assign busy        = (state == CALC);
    assign done        = (state == DONE);
    assign div_by_zero = done & isDiv & bZero;
    assign stall_req   = mf_req & busy;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (startAccept) stateNext = CALC;
            CALC: begin
                if (flush | mtWrite)  stateNext = IDLE;
                else if (lastIter)    stateNext = DONE;
            end
            DONE:    stateNext = startAccept ? CALC : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Iteration step: multiply consumes accLo[0]; divide shifts the dividend out of accLo[MSB]
    always_comb begin
        mulSum  = {1'b0, accHi} + (accLo[0] ? {1'b0, opA} : '0);
        divTmp  = {accHi, accLo[WIDTH-1]};
        divGe   = divTmp >= {1'b0, opB};
        divDiff = divTmp[WIDTH-1:0] - opB;
        if (isDiv) begin
            iterHi = divGe ? divDiff : divTmp[WIDTH-1:0];
            iterLo = {accLo[WIDTH-2:0], divGe};
        end else begin
            iterHi = mulSum[WIDTH:1];
            iterLo = {mulSum[0], accLo[WIDTH-1:1]};
        end
    end

    always_comb begin
        prodFix = condNeg2({iterHi, iterLo}, negRes);
        resHi   = prodFix[2*WIDTH-1:WIDTH];
        resLo   = prodFix[WIDTH-1:0];
        if (isDiv) begin
            if (bZero) begin
                resHi = aRaw;
                resLo = '1;
            end else begin
                resHi = condNeg(iterHi, negRem);
                resLo = condNeg(iterLo, negRes);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (startAccept) begin
            isDiv  <= op[1];
            negRes <= signedOp & (a[WIDTH-1] ^ b[WIDTH-1]);
            negRem <= signedOp & a[WIDTH-1];
            bZero  <= (b == '0);
            aRaw   <= a;
            opA    <= absA;
            opB    <= absB;
            accHi  <= '0;
            accLo  <= op[1] ? absA : absB;
        end else if (state == CALC) begin
            accHi  <= iterHi;
            accLo  <= iterLo;
        end
    end

    // Flush suppresses everything; an mt write lands after the result so it wins in the done edge
    always_ff @(posedge clk) begin
        if (rst) begin
            hi    <= '0;
            lo    <= '0;
            count <= '0;
        end else begin
            if (startAccept)         count <= '0;
            else if (state == CALC)  count <= count + CNT_W'(1);
            if (!flush) begin
                if (finish) begin
                    hi <= resHi;
                    lo <= resLo;
                end
                if (mthi_we) hi <= mt_data;
                if (mtlo_we) lo <= mt_data;
            end
        end
    end

endmodule

// File: tb/tb_md_hilo_unit.sv
// Directed bench for md_hilo_unit: expected HI/LO/div_by_zero are queued at start and
// compared when done pulses; control timing and abort paths are checked inline.
module tb_md_hilo_unit;

    localparam int W  = 32;
    localparam int CW = $clog2(W) + 1;

    logic         clk = 1'b0;
    logic         rst, start, flush, mthi_we, mtlo_we, mf_req;
    logic [1:0]   op;
    logic [W-1:0] a, b, mt_data;
    logic [W-1:0] hi, lo;
    logic         busy, done, div_by_zero, stall_req;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] h;
        logic [W-1:0] l;
        logic         d;
    } exp_t;

    exp_t         sb[$];
    exp_t         cur;
    logic [W-1:0] curHi, curLo;

    md_hilo_unit #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_data(mt_data),
        .mf_req(mf_req), .hi(hi), .lo(lo), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
        logic [2*W-1:0] p;
        longint sx, sy, q, r;
        ed = 1'b0;
        eh = '0;
        el = '0;
        case (o)
            2'd0: begin
                p  = {{W{x[W-1]}}, x} * {{W{y[W-1]}}, y};
                eh = p[2*W-1:W];
                el = p[W-1:0];
            end
            2'd1: begin
                p  = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                eh = p[2*W-1:W];
                el = p[W-1:0];
            end
            default: begin
                if (y == '0) begin
                    ed = 1'b1;
                    eh = x;
                    el = '1;
                end else if (o == 2'd3) begin
                    el = x / y;
                    eh = x % y;
                end else begin
                    sx = longint'($signed(x));
                    sy = longint'($signed(y));
                    q  = sx / sy;
                    r  = sx % sy;
                    el = q[W-1:0];
                    eh = r[W-1:0];
                end
            end
        endcase
    endfunction

    // Scoreboard consumer: every done must match the oldest queued result
    always @(negedge clk) begin
        if (done) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_done observed=1 expected=0");
            end
            if (sb.size() != 0) begin
                cur = sb.pop_front();
                chk("sb_hi", hi, cur.h);
                chk("sb_lo", lo, cur.l);
                chk("sb_dz", W'(div_by_zero), W'(cur.d));
            end
        end else begin
            chk("dz_idle", W'(div_by_zero), '0);
        end
    end

    // Called at a negedge; returns at the negedge of the done cycle
    task automatic runOp(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic withMtHi);
        logic [W-1:0] eh, el;
        logic         ed;
        int           n;
        model(o, x, y, eh, el, ed);
        sb.push_back('{h: eh, l: el, d: ed});
        curHi   = eh;
        curLo   = el;
        start   = 1'b1;
        op      = o;
        a       = x;
        b       = y;
        mthi_we = withMtHi;
        mt_data = W'(32'h77);
        @(negedge clk);
        start   = 1'b0;
        mthi_we = 1'b0;
        op      = ~o;
        a       = W'($urandom);
        b       = W'($urandom);
        chk("busy_first", W'(busy), W'(1));
        chk("stall_busy", W'(stall_req), W'(mf_req));
        if (withMtHi) chk("mthi_with_start", hi, W'(32'h77));
        n = 1;
        while (!done && n < W + 8) begin
            @(negedge clk);
            n++;
        end
        chk("latency", W'(n), W'(W + 1));
        chk("busy_done", W'(busy), '0);
        chk("stall_done", W'(stall_req), '0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
        mf_req = 1'b1; op = 2'd0; a = '0; b = '0; mt_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_stall", W'(stall_req), '0);
        rst = 1'b0;
        mf_req = 1'b0;
        @(negedge clk);

        runOp(2'd1, '1, W'(2), 1'b0);
        runOp(2'd0, W'(-7), W'(3), 1'b0);
        runOp(2'd2, W'(-7), W'(2), 1'b0);
        runOp(2'd3, W'(32'h1234), '0, 1'b0);
        runOp(2'd3, W'(10), W'(3), 1'b0);
        runOp(2'd2, {1'b1, {(W-1){1'b0}}}, '1, 1'b0);
        runOp(2'd0, {1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}}, 1'b0);
        runOp(2'd2, W'(7), '0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            runOp(2'($urandom_range(0, 3)), W'($urandom), (i == 5) ? '0 : W'($urandom), 1'b0);
        end
        @(negedge clk);

        // flush ten cycles into a MULT
        start = 1'b1; op = 2'd0; a = W'(5); b = W'(9);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", W'(busy), '0);
        chk("flush_hi", hi, curHi);
        chk("flush_lo", lo, curLo);
        repeat (W + 3) @(negedge clk);

        // MTHI five cycles into a MULT
        start = 1'b1; op = 2'd0; a = W'(11); b = W'(13);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        mthi_we = 1'b1; mt_data = W'(32'hAA);
        @(negedge clk);
        mthi_we = 1'b0;
        curHi = W'(32'hAA);
        chk("mthi_hi", hi, curHi);
        chk("mthi_lo", lo, curLo);
        chk("mthi_busy", W'(busy), '0);
        repeat (W + 3) @(negedge clk);

        // stall while busy, then a back-to-back start in the done cycle
        mf_req = 1'b1;
        runOp(2'd0, W'(-100), W'(37), 1'b0);
        runOp(2'd3, W'(1000), W'(7), 1'b0);
        mf_req = 1'b0;

        // MTLO in the done cycle overrides the fresh LO only
        mtlo_we = 1'b1; mt_data = W'(32'h55);
        @(negedge clk);
        mtlo_we = 1'b0;
        chk("mtlo_done_lo", lo, W'(32'h55));
        chk("mtlo_done_hi", hi, curHi);
        chk("mtlo_done_busy", W'(busy), '0);

        // start together with MTHI from IDLE
        runOp(2'd1, W'(3), W'(4), 1'b1);
        @(negedge clk);

        // reset in the middle of a DIV
        start = 1'b1; op = 2'd2; a = W'(-50); b = W'(3);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_hi", hi, '0);
        chk("midrst_lo", lo, '0);
        chk("midrst_busy", W'(busy), '0);
        chk("midrst_done", W'(done), '0);
        repeat (W + 3) @(negedge clk);

        chk("sb_drained", W'(sb.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
